regbank_scoreboard: RTL and testbench

Parametrised successor to the 16×16 register bank: a DEPTH×WIDTH register file with two registered read ports, one write port, optional write-to-read bypass, optional hardwired zero register, and a per-register busy scoreboard for pipeline hazard detection. It sits between the decode and writeback stages of the pipelined microprocessor. Decode reads operands and scoreboard status through it and marks destination registers as pending. Writeback stores results and clears the pending marks.

---
 rtl/regbank_scoreboard_if.sv | 29 ++
 rtl/regbank_scoreboard.sv | 102 ++++++++++
 tb/tb_regbank_scoreboard.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/regbank_scoreboard_if.sv
// Decode/writeback bus of the register bank: read, write and issue channels.
// The master modport belongs to the pipeline and the slave modport to the bank.
interface regbank_scoreboard_if #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 4
);
  logic [ADDR_W-1:0] AddrRegA;
  logic [ADDR_W-1:0] AddrRegB;
  logic              Hold;
  logic              WEN;
  logic [ADDR_W-1:0] AddrWriteReg;
  logic [WIDTH-1:0]  Data;
  logic              IssueEn;
  logic [ADDR_W-1:0] AddrIssue;
  logic [WIDTH-1:0]  RegA;
  logic [WIDTH-1:0]  RegB;
  logic              BusyA;
  logic              BusyB;

  modport master (
    output AddrRegA, AddrRegB, Hold, WEN, AddrWriteReg, Data, IssueEn, AddrIssue,
    input  RegA, RegB, BusyA, BusyB
  );

  modport slave (
    input  AddrRegA, AddrRegB, Hold, WEN, AddrWriteReg, Data, IssueEn, AddrIssue,
    output RegA, RegB, BusyA, BusyB
  );
endinterface

// File: rtl/regbank_scoreboard.sv
// DEPTH x WIDTH register file with two registered read ports, one write port
// and a per-register busy bit used by decode for hazard detection.
module regbank_scoreboard #(
  parameter int WIDTH    = 16,
  parameter int ADDR_W   = 4,
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 1
) (
  input  logic                 CLK,
  input  logic                 RST,
  regbank_scoreboard_if.slave  bus
);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0] busy_q, busy_d;
  logic [WIDTH-1:0] rega_q, rega_d, regb_q, regb_d;
  logic             busya_q, busya_d, busyb_q, busyb_d;
  logic             wr_ok_s, iss_ok_s;

  // Register 0 is immune to writes and issues when it is hardwired to zero.
  assign wr_ok_s  = bus.WEN     && !((ZERO_REG != 0) && (bus.AddrWriteReg == '0));
  assign iss_ok_s = bus.IssueEn && !((ZERO_REG != 0) && (bus.AddrIssue == '0));

  // Next storage and busy state; issue is applied after the write so it wins.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      regs_d[i] = regs_q[i];
    end
    busy_d = busy_q;
    if (wr_ok_s) begin
      regs_d[bus.AddrWriteReg] = bus.Data;
      busy_d[bus.AddrWriteReg] = 1'b0;
    end else begin
      busy_d = busy_d;
    end
    if (iss_ok_s) begin
      busy_d[bus.AddrIssue] = 1'b1;
    end else begin
      busy_d = busy_d;
    end
  end

  // Next read-port values: optional forwarding first, zero masking last.
  always_comb begin
    rega_d  = rega_q;
    regb_d  = regb_q;
    busya_d = busya_q;
    busyb_d = busyb_q;
    if (!bus.Hold) begin
      rega_d  = ((BYPASS != 0) && bus.WEN && (bus.AddrWriteReg == bus.AddrRegA)) ?
                bus.Data : regs_q[bus.AddrRegA];
      regb_d  = ((BYPASS != 0) && bus.WEN && (bus.AddrWriteReg == bus.AddrRegB)) ?
                bus.Data : regs_q[bus.AddrRegB];
      busya_d = (BYPASS != 0) ? busy_d[bus.AddrRegA] : busy_q[bus.AddrRegA];
      busyb_d = (BYPASS != 0) ? busy_d[bus.AddrRegB] : busy_q[bus.AddrRegB];
      if ((ZERO_REG != 0) && (bus.AddrRegA == '0)) begin
        rega_d  = '0;
        busya_d = 1'b0;
      end else begin
        busya_d = busya_d;
      end
      if ((ZERO_REG != 0) && (bus.AddrRegB == '0)) begin
        regb_d  = '0;
        busyb_d = 1'b0;
      end else begin
        busyb_d = busyb_d;
      end
    end else begin
      rega_d = rega_q;
    end
  end

  // State and output registers; reset overrides every other input.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      busy_q  <= '0;
      rega_q  <= '0;
      regb_q  <= '0;
      busya_q <= 1'b0;
      busyb_q <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= regs_d[i];
      end
      busy_q  <= busy_d;
      rega_q  <= rega_d;
      regb_q  <= regb_d;
      busya_q <= busya_d;
      busyb_q <= busyb_d;
    end
  end

  assign bus.RegA  = rega_q;
  assign bus.RegB  = regb_q;
  assign bus.BusyA = busya_q;
  assign bus.BusyB = busyb_q;
endmodule

// File: tb/tb_regbank_scoreboard.sv
// Bench for regbank_scoreboard: three configurations (bypass, no bypass,
// bypass with zero register) share one stimulus and one expected-value queue.
module tb_regbank_scoreboard;
  typedef logic [2:0][33:0] exp_t;

  logic        clk = 1'b0;
  logic        rst_s = 1'b0, hold_s = 1'b0, wen_s = 1'b0, iss_s = 1'b0;
  logic [3:0]  aw_s = 4'd0, ai_s = 4'd0, ra_s = 4'd0, rb_s = 4'd0;
  logic [15:0] data_s = 16'h0000;

  int total = 0;
  int bad   = 0;
  int step_n = 0;

  logic [15:0] mreg  [3][16];
  logic [15:0] mbusy [3];
  logic [33:0] mout  [3];
  exp_t        sbq [$];
  logic [33:0] obs_w [3];

  always #5 clk = ~clk;

  regbank_scoreboard_if #(.WIDTH(16), .ADDR_W(4)) ifs [3] ();

  for (genvar g = 0; g < 3; g++) begin : g_drv
    assign ifs[g].AddrRegA     = ra_s;
    assign ifs[g].AddrRegB     = rb_s;
    assign ifs[g].Hold         = hold_s;
    assign ifs[g].WEN          = wen_s;
    assign ifs[g].AddrWriteReg = aw_s;
    assign ifs[g].Data         = data_s;
    assign ifs[g].IssueEn      = iss_s;
    assign ifs[g].AddrIssue    = ai_s;
    assign obs_w[g] = {ifs[g].RegA, ifs[g].RegB, ifs[g].BusyA, ifs[g].BusyB};
  end

  regbank_scoreboard #(.WIDTH(16), .ADDR_W(4), .ZERO_REG(0), .BYPASS(1)) dut_byp (
    .CLK(clk), .RST(rst_s), .bus(ifs[0]));
  regbank_scoreboard #(.WIDTH(16), .ADDR_W(4), .ZERO_REG(0), .BYPASS(0)) dut_nbyp (
    .CLK(clk), .RST(rst_s), .bus(ifs[1]));
  regbank_scoreboard #(.WIDTH(16), .ADDR_W(4), .ZERO_REG(1), .BYPASS(1)) dut_zero (
    .CLK(clk), .RST(rst_s), .bus(ifs[2]));

  task automatic check(input string tag, input logic [33:0] obs, input logic [33:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle, predict all three configurations, compare after the edge.
  task automatic step(input logic rst, input logic hold, input logic wen,
                      input logic [3:0] aw, input logic [15:0] d, input logic iss,
                      input logic [3:0] ai, input logic [3:0] ra, input logic [3:0] rb);
    exp_t        e, got;
    logic [15:0] nb, a_d, b_d;
    logic        a_b, b_b, wok, iok, byp, zr;
    rst_s = rst; hold_s = hold; wen_s = wen; aw_s = aw; data_s = d;
    iss_s = iss; ai_s = ai; ra_s = ra; rb_s = rb;
    for (int c = 0; c < 3; c++) begin
      byp = (c != 1);
      zr  = (c == 2);
      wok = wen && !(zr && aw == 4'd0);
      iok = iss && !(zr && ai == 4'd0);
      nb = mbusy[c];
      if (wok) nb[aw] = 1'b0;
      if (iok) nb[ai] = 1'b1;
      if (rst) begin
        e[c] = 34'd0;
      end else if (hold) begin
        e[c] = mout[c];
      end else begin
        a_d = (byp && wen && aw == ra) ? d : mreg[c][ra];
        b_d = (byp && wen && aw == rb) ? d : mreg[c][rb];
        a_b = byp ? nb[ra] : mbusy[c][ra];
        b_b = byp ? nb[rb] : mbusy[c][rb];
        if (zr && ra == 4'd0) begin a_d = 16'h0000; a_b = 1'b0; end
        if (zr && rb == 4'd0) begin b_d = 16'h0000; b_b = 1'b0; end
        e[c] = {a_d, b_d, a_b, b_b};
      end
      mout[c] = e[c];
      if (rst) begin
        for (int i = 0; i < 16; i++) mreg[c][i] = 16'h0000;
        mbusy[c] = 16'h0000;
      end else begin
        if (wok) mreg[c][aw] = d;
        mbusy[c] = nb;
      end
    end
    sbq.push_back(e);
    @(posedge clk);
    #1;
    got = sbq.pop_front();
    for (int c = 0; c < 3; c++) begin
      check($sformatf("step%0d_cfg%0d", step_n, c), obs_w[c], got[c]);
    end
    step_n++;
  endtask

  initial begin
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < 16; i++) mreg[c][i] = 16'h0000;
      mbusy[c] = 16'h0000;
      mout[c]  = 34'd0;
    end
    // reset, preload r3 and mark it busy, then reset with conflicting inputs
    step(1'b1, 1'b0, 1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 4'd0, 4'd0);
    check("reset_outputs", obs_w[0], 34'd0);
    step(1'b0, 1'b0, 1'b1, 4'd3, 16'hBEEF, 1'b0, 4'd0, 4'd3, 4'd3);
    step(1'b0, 1'b0, 1'b0, 4'd0, 16'h0000, 1'b1, 4'd3, 4'd3, 4'd3);
    check("preload_r3", obs_w[0], {16'hBEEF, 16'hBEEF, 1'b1, 1'b1});
    step(1'b1, 1'b1, 1'b1, 4'd3, 16'h1111, 1'b1, 4'd3, 4'd3, 4'd3);
    step(1'b0, 1'b0, 1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 4'd3, 4'd3);
    check("r3_after_reset", obs_w[0], 34'd0);
    // write-to-read forwarding vs one-cycle-late visibility
    step(1'b0, 1'b0, 1'b1, 4'd5, 16'h1234, 1'b0, 4'd0, 4'd5, 4'd0);
    check("bypass_same_edge", {18'd0, obs_w[0][33:18]}, {18'd0, 16'h1234});
    check("nobypass_old", {18'd0, obs_w[1][33:18]}, {18'd0, 16'h0000});
    step(1'b0, 1'b0, 1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 4'd5, 4'd0);
    check("nobypass_next_edge", {18'd0, obs_w[1][33:18]}, {18'd0, 16'h1234});
    // scoreboard set and clear on register 7
    step(1'b0, 1'b0, 1'b0, 4'd0, 16'h0000, 1'b1, 4'd7, 4'd7, 4'd0);
    check("issue7_busy_byp", {33'd0, obs_w[0][1]}, 34'd1);
    step(1'b0, 1'b0, 1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 4'd7, 4'd0);
    step(1'b0, 1'b0, 1'b1, 4'd7, 16'h00AA, 1'b0, 4'd0, 4'd7, 4'd0);
    check("write7_clears", {17'd0, obs_w[0][33:18], obs_w[0][1]}, {17'd0, 16'h00AA, 1'b0});
    // simultaneous write+issue, then independent issue and write
    step(1'b0, 1'b0, 1'b1, 4'd2, 16'h2222, 1'b1, 4'd2, 4'd2, 4'd2);
    check("wr_iss_same", obs_w[0], {16'h2222, 16'h2222, 1'b1, 1'b1});
    step(1'b0, 1'b0, 1'b1, 4'd9, 16'h9999, 1'b1, 4'd2, 4'd2, 4'd9);
    step(1'b0, 1'b0, 1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 4'd2, 4'd9);
    check("iss2_wr9", obs_w[1], {16'h2222, 16'h9999, 1'b1, 1'b0});
    // busy is one bit: double issue, single write clears
    step(1'b0, 1'b0, 1'b0, 4'd0, 16'h0000, 1'b1, 4'd6, 4'd6, 4'd6);
    step(1'b0, 1'b0, 1'b0, 4'd0, 16'h0000, 1'b1, 4'd6, 4'd6, 4'd6);
    step(1'b0, 1'b0, 1'b1, 4'd6, 16'h0066, 1'b0, 4'd0, 4'd6, 4'd6);
    step(1'b0, 1'b0, 1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 4'd6, 4'd6);
    check("single_clear", obs_w[1], {16'h0066, 16'h0066, 1'b0, 1'b0});
    // hold for three cycles while writing register 4
    step(1'b0, 1'b1, 1'b1, 4'd4, 16'h5555, 1'b0, 4'd0, 4'd0, 4'd4);
    step(1'b0, 1'b1, 1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 4'd0, 4'd4);
    step(1'b0, 1'b1, 1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 4'd0, 4'd4);
    check("hold_frozen", {18'd0, obs_w[1][17:2]}, {18'd0, 16'h0066});
    step(1'b0, 1'b0, 1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 4'd0, 4'd4);
    check("hold_release", {18'd0, obs_w[1][17:2]}, {18'd0, 16'h5555});
    // hardwired zero register
    step(1'b0, 1'b0, 1'b1, 4'd0, 16'hFFFF, 1'b1, 4'd0, 4'd0, 4'd0);
    check("zero_same_edge", obs_w[2], 34'd0);
    step(1'b0, 1'b0, 1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 4'd0, 4'd0);
    check("zero_reg_read", obs_w[2], 34'd0);
    check("nonzero_cfg_r0", obs_w[0], {16'hFFFF, 16'hFFFF, 1'b1, 1'b1});
    // mixed random traffic against the model
    for (int n = 0; n < 60; n++) begin
      step(($urandom_range(0, 29) == 0), ($urandom_range(0, 3) == 0),
           1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 16'($urandom),
           1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
           4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    end
    // reset in the middle of a hold
    step(1'b0, 1'b1, 1'b1, 4'd8, 16'h8888, 1'b1, 4'd8, 4'd8, 4'd8);
    step(1'b1, 1'b1, 1'b1, 4'd8, 16'h7777, 1'b1, 4'd8, 4'd8, 4'd8);
    step(1'b0, 1'b0, 1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 4'd8, 4'd8);
    check("reset_mid_hold", obs_w[0], 34'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
